clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 135 +++++++++++++
 tb/tb_clk_div_multi.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel divided clocks with shadowed, wrap-aligned config.
// Define CLK_DIV_PHASE_SYNC_EN to let the sync strobe realign all enabled channels.
module clk_div_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 16,
    parameter int DEF_HIGH = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    logic [CNT_W-1:0]  div_q     [NUM_CH];
    logic [CNT_W-1:0]  div_d     [NUM_CH];
    logic [CNT_W-1:0]  high_q    [NUM_CH];
    logic [CNT_W-1:0]  high_d    [NUM_CH];
    logic [CNT_W-1:0]  sh_div_q  [NUM_CH];
    logic [CNT_W-1:0]  sh_div_d  [NUM_CH];
    logic [CNT_W-1:0]  sh_high_q [NUM_CH];
    logic [CNT_W-1:0]  sh_high_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic              err_q, err_d;
    logic              cfg_bad;
    logic              xfer;
    logic              sync_s;

`ifdef CLK_DIV_PHASE_SYNC_EN
    assign sync_s = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_s      = 1'b0;
`endif

    // Out-of-range channel numbers never match, so they are never ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_q[i];
        end
    end

    assign cfg_bad = (cfg_div < CNT_W'(2)) ||
                     (cfg_high == '0) ||
                     (cfg_high >= cfg_div);
    assign xfer    = cfg_valid && cfg_ready;
    assign err_d   = xfer && cfg_bad;

    // Every path that lands cnt on 0 is a safe point to swap in the shadow.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]     = div_q[i];
            high_d[i]    = high_q[i];
            sh_div_d[i]  = sh_div_q[i];
            sh_high_d[i] = sh_high_q[i];
            pend_d[i]    = pend_q[i];
            if (!ch_en[i] || !run_q[i] || sync_s) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= div_q[i] - CNT_W'(1)) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (pend_q[i] && (cnt_d[i] == '0)) begin
                div_d[i]  = sh_div_q[i];
                high_d[i] = sh_high_q[i];
                pend_d[i] = 1'b0;
            end
            if (xfer && !cfg_bad && (cfg_ch == CH_W'(i))) begin
                sh_div_d[i]  = cfg_div;
                sh_high_d[i] = cfg_high;
                pend_d[i]    = 1'b1;
            end
            clk_d[i]  = ch_en[i] && (cnt_d[i] < high_d[i]);
            rise_d[i] = clk_d[i] && !clk_q[i];
            fall_d[i] = !clk_d[i] && clk_q[i];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]     <= CNT_W'(DEF_DIV);
                high_q[i]    <= CNT_W'(DEF_HIGH);
                sh_div_q[i]  <= '0;
                sh_high_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
            pend_q <= '0;
            run_q  <= '0;
            clk_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]     <= div_d[i];
                high_q[i]    <= high_d[i];
                sh_div_q[i]  <= sh_div_d[i];
                sh_high_q[i] <= sh_high_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
            pend_q <= pend_d;
            run_q  <= ch_en;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            err_q  <= err_d;
        end
    end

    assign clk_out = clk_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues expected samples per edge,
// a negedge monitor pops and compares them.
module tb_clk_div_multi;

    localparam int K_CLK  = 0;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_ERR  = 3;
    localparam int K_RDY  = 4;

`ifdef CLK_DIV_PHASE_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    typedef struct {
        int   e;
        int   kind;
        int   ch;
        logic v;
    } exp_t;

    logic        clk_in;
    logic        reset_n;
    logic [3:0]  ch_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic        cfg_err;
    logic        sync;
    logic [3:0]  clk_out;
    logic [3:0]  rise;
    logic [3:0]  fall;

    exp_t sbq[$];
    int   ecount = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   e0, e1, e2, e3, e4, e5, b1;

    clk_div_multi dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .sync      (sync),
        .clk_out   (clk_out),
        .rise      (rise),
        .fall      (fall)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) ecount++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    function automatic void push(input int e, input int kind,
                                 input int ch, input logic v);
        exp_t x;
        x.e = e;
        x.kind = kind;
        x.ch = ch;
        x.v = v;
        sbq.push_back(x);
    endfunction

    // Ideal divided clock: phase m within a d-cycle period, high for h.
    function automatic void push_pat(input int e, input int ch,
                                     input int m, input int d, input int h);
        int p;
        p = m % d;
        push(e, K_CLK, ch, p < h);
        push(e, K_RISE, ch, p == 0);
        push(e, K_FALL, ch, p == h);
    endfunction

    function automatic logic sample(input int kind, input int ch);
        case (kind)
            K_CLK:   return clk_out[ch];
            K_RISE:  return rise[ch];
            K_FALL:  return fall[ch];
            K_ERR:   return cfg_err;
            default: return cfg_ready;
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_CLK:   return "clk_out";
            K_RISE:  return "rise";
            K_FALL:  return "fall";
            K_ERR:   return "cfg_err";
            default: return "cfg_ready";
        endcase
    endfunction

    initial begin
        exp_t x;
        logic got;
        forever begin
            @(negedge clk_in);
            while (sbq.size() != 0 && sbq[0].e <= ecount) begin
                x = sbq.pop_front();
                got = sample(x.kind, x.ch);
                n_vec++;
                if (x.e != ecount || got !== x.v) begin
                    n_err++;
                    $display("FAIL %s ch%0d edge %0d (at %0d): got %0b want %0b",
                             kname(x.kind), x.ch, x.e, ecount, got, x.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        ch_en = '0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        cfg_high = '0;
        sync = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            for (int c = 0; c < 4; c++) begin
                push(e, K_CLK, c, 1'b0);
                push(e, K_RISE, c, 1'b0);
                push(e, K_FALL, c, 1'b0);
            end
            push(e, K_ERR, 0, 1'b0);
            push(e, K_RDY, 0, 1'b1);
        end
        tick(2);
        n_vec++;
        if (clk_out !== 4'b0000 || rise !== 4'b0000 ||
            fall !== 4'b0000 || cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL outputs not cleared in reset");
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_ready low after reset release");
        end

        // default 16/8 on ch0, ready swept over all channels
        e0 = ecount;
        for (int k = 1; k <= 32; k++) begin
            if (k == 1) ch_en = 4'b0001;
            cfg_ch = 2'(k % 4);
            push_pat(e0 + k, 0, k - 1, 16, 8);
            push(e0 + k, K_RDY, k % 4, 1'b1);
            tick(1);
        end

        // ch1 reconfigured to 5/2 mid-period
        e1 = ecount;
        cfg_ch = 2'd1;
        for (int n = 1; n <= 32; n++) begin
            if (n == 1) ch_en = 4'b0011;
            if (n == 5) begin
                cfg_valid = 1'b1;
                cfg_div = 16'd5;
                cfg_high = 16'd2;
            end
            if (n == 6) cfg_valid = 1'b0;
            if (n <= 16) push_pat(e1 + n, 1, n - 1, 16, 8);
            else push_pat(e1 + n, 1, n - 17, 5, 2);
            if (n <= 20) push(e1 + n, K_RDY, 1, !(n >= 5 && n <= 16));
            if (n == 6) push(e1 + n, K_ERR, 1, 1'b0);
            tick(1);
        end
        b1 = e1 + 17;

        // three illegal requests back to back
        e2 = ecount;
        for (int n = 1; n <= 10; n++) begin
            case (n)
                1: begin
                    cfg_valid = 1'b1;
                    cfg_div = 16'd1;
                    cfg_high = 16'd1;
                end
                2: begin
                    cfg_div = 16'd6;
                    cfg_high = 16'd0;
                end
                3: begin
                    cfg_div = 16'd6;
                    cfg_high = 16'd6;
                end
                4: cfg_valid = 1'b0;
                default: ;
            endcase
            push_pat(e2 + n, 1, e2 + n - b1, 5, 2);
            if (n <= 6) begin
                push(e2 + n, K_ERR, 1, n <= 3);
                push(e2 + n, K_RDY, 1, 1'b1);
            end
            tick(1);
        end

        // ch2 dropped while high, then re-enabled
        e3 = ecount;
        for (int n = 1; n <= 14; n++) begin
            if (n == 1) ch_en = 4'b0111;
            if (n == 3) ch_en = 4'b0011;
            if (n == 5) ch_en = 4'b0111;
            if (n <= 2) begin
                push_pat(e3 + n, 2, n - 1, 16, 8);
            end else if (n <= 4) begin
                push(e3 + n, K_CLK, 2, 1'b0);
                push(e3 + n, K_RISE, 2, 1'b0);
                push(e3 + n, K_FALL, 2, n == 3);
            end else begin
                push_pat(e3 + n, 2, n - 5, 16, 8);
            end
            tick(1);
        end

        // ch2 at 6/3, ch3 at 10/5, sync strobe at edge e4+14
        e4 = ecount;
        for (int n = 1; n <= 34; n++) begin
            case (n)
                1: begin
                    ch_en = 4'b0011;
                    cfg_valid = 1'b1;
                    cfg_ch = 2'd2;
                    cfg_div = 16'd6;
                    cfg_high = 16'd3;
                end
                2: begin
                    cfg_ch = 2'd3;
                    cfg_div = 16'd10;
                    cfg_high = 16'd5;
                end
                3: cfg_valid = 1'b0;
                4: ch_en = 4'b0111;
                7: ch_en = 4'b1111;
                14: sync = 1'b1;
                15: sync = 1'b0;
                default: ;
            endcase
            if (n <= 4) push(e4 + n, K_ERR, 0, 1'b0);
            if (n >= 8) begin
                if (SYNC_ON && n >= 14) begin
                    push_pat(e4 + n, 2, n - 14, 6, 3);
                    push_pat(e4 + n, 3, n - 14, 10, 5);
                end else begin
                    push_pat(e4 + n, 2, n - 4, 6, 3);
                    push_pat(e4 + n, 3, n - 7, 10, 5);
                end
            end
            tick(1);
        end

        // reset with a request pending on ch0
        e5 = ecount;
        cfg_valid = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = 16'd4;
        cfg_high = 16'd1;
        push(e5 + 1, K_RDY, 0, 1'b0);
        push(e5 + 1, K_ERR, 0, 1'b0);
        tick(1);
        cfg_valid = 1'b0;
        tick(1);
        reset_n = 1'b0;
        ch_en = 4'b0001;
        #1;
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++;
            $display("FAIL clk_out not cleared immediately by reset");
        end
        n_vec++;
        if (rise !== 4'b0000 || fall !== 4'b0000) begin
            n_err++;
            $display("FAIL rise/fall not cleared immediately by reset");
        end
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err not cleared immediately by reset");
        end
        for (int c = 0; c < 4; c++) begin
            push(e5 + 2, K_CLK, c, 1'b0);
            push(e5 + 2, K_RISE, c, 1'b0);
            push(e5 + 2, K_FALL, c, 1'b0);
        end
        push(e5 + 2, K_ERR, 0, 1'b0);
        push(e5 + 2, K_RDY, 0, 1'b1);
        tick(1);
        push(e5 + 3, K_CLK, 0, 1'b0);
        push(e5 + 3, K_RISE, 0, 1'b0);
        push(e5 + 3, K_FALL, 0, 1'b0);
        reset_n = 1'b1;
        for (int n = 4; n <= 40; n++) begin
            push_pat(e5 + n, 0, n - 4, 16, 8);
            tick(1);
        end

        for (int i = 0; i < 4 && sbq.size() != 0; i++) tick(1);
        while (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s ch%0d edge %0d: never sampled",
                     kname(sbq[0].kind), sbq[0].ch, sbq[0].e);
            void'(sbq.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else $display("FAIL %0d miscompares", n_err);
        $finish;
    end

endmodule
